tdm_demux_4ch: RTL and testbench
================================

TDM_DEMUX_4CH -- requirements
Module: tdm_demux_4ch

Interface
REQ-001 Parameter: SYNC_LOSS_MAX, default 2; number of consecutive misplaced sync markers that drops lock.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 Port: en  in  1  bit strobe; din/sync are sampled only in cycles with en=1.
REQ-005 Port: din  in  1  serial TDM data bit; one channel bit per strobe.
REQ-006 Port: sync  in  1  frame marker; qualifies the current din bit as slot 0.
REQ-007 Port: dout  out  4  last complete frame; bit i = channel i.
REQ-008 Port: dout_valid  out  1  one-cycle pulse; dout updated this cycle.
REQ-009 Port: ch_sel  out  2  slot index the next strobed bit is written to; 0 in HUNT.
REQ-010 Port: locked  out  1  high in LOCKED state.
REQ-011 Port: sync_err  out  1  one-cycle pulse on a misplaced sync.

Function
REQ-012 The block SHALL implement an FSM with states HUNT and LOCKED, plus a 2-bit slot counter, a 3-bit shadow register and a miss counter.
REQ-013 When en=0, the block SHALL hold all state; dout_valid and sync_err SHALL be 0.
REQ-014 In HUNT, strobes with sync=0 SHALL be discarded.
REQ-015 In HUNT, a strobe with sync=1 SHALL write din to shadow[0], set slot to 1, clear the miss counter and enter LOCKED.
REQ-016 In LOCKED, a strobe at slot s (s=0..2) SHALL write din to shadow[s] and set slot to s+1.
REQ-017 In LOCKED, a strobe at slot 3 SHALL load dout with {din, shadow[2:0]}, pulse dout_valid and wrap slot to 0.
REQ-018 dout_valid SHALL be asserted in the cycle after the slot-3 strobe edge; latency from the slot-3 bit to dout is one clock.
REQ-019 dout SHALL hold its value between frames; partial frames SHALL never appear on dout.
REQ-020 In LOCKED, sync=1 at slot 0 SHALL clear the miss counter.
REQ-021 In LOCKED, no sync at slot 0 SHALL be tolerated (flywheel) and leave the miss counter unchanged.
REQ-022 In LOCKED, sync=1 at slot≠0 SHALL pulse sync_err, discard the partial frame and increment the miss counter.
REQ-023 If the incremented miss count is below SYNC_LOSS_MAX, the REQ-022 strobe SHALL be treated as slot 0 (realign): shadow[0]=din, slot=1.
REQ-024 If the incremented miss count reaches SYNC_LOSS_MAX, the REQ-022 strobe SHALL be dropped, with slot=0, miss=0 and state=HUNT.
REQ-025 The miss counter SHALL saturate and never wrap.
REQ-026 sync_err and dout_valid SHALL never assert in the same cycle, because a misplaced sync cannot occur at slot 3 completion; sync at slot 3 follows REQ-022 and produces no frame.

Reset
REQ-027 With rst_n=0 at a clock edge, the block SHALL set: state=HUNT, slot=0, miss=0, shadow=0, dout=4'b0000, dout_valid=0, sync_err=0, locked=0, ch_sel=0.
REQ-028 Reset SHALL take priority over en/sync in the same cycle.
REQ-029 Reset mid-frame SHALL discard the partial frame.

Structure
REQ-030 Shared package tdm_pkg SHALL hold the state enum (HUNT, LOCKED), NUM_CH=4 and SLOT_W=2.
REQ-031 Sub-module demux_1to4 SHALL be a combinational decoder turning (slot, strobe) into four one-hot write enables for the shadow/dout bits.

Verification
REQ-032 Reset, then strobes with sync on bit 0 and din=1,0,1,1 -> dout=4'b1101, one dout_valid pulse one clock after the 4th strobe, locked=1.
REQ-033 Locked; strobes interleaved with en=0 gaps of 0-3 cycles, frame 0,1,1,0 -> dout=4'b0110; ch_sel constant during gaps.
REQ-034 Locked; sync at slot 2 once -> sync_err pulse, miss=1, realign; the next 4 bits 1,1,1,1 -> dout=4'b1111 and dout unchanged before that.
REQ-035 Locked, SYNC_LOSS_MAX=2; sync at slot 1 in two consecutive frames with no good sync between -> second sync_err, locked=0, ch_sel=0, no dout_valid.
REQ-036 Frame half received, rst_n=0 one cycle with en=1 -> all outputs 0, state HUNT; the next sync re-acquires cleanly.
REQ-037 Locked, no sync for 3 frames -> flywheel, three dout_valid pulses, sync_err never asserted.

Source files
------------

// File: rtl/tdm_demux_4ch_pkg.sv
// Shared types and sizing for the 4-channel TDM demultiplexer.
package tdm_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SLOT_W = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux_4ch_if.sv
// Serial TDM input side and parallel frame output side of the demultiplexer.
interface tdm_demux_4ch_if;
  import tdm_pkg::*;

  logic                en;
  logic                din;
  logic                sync;
  logic [NUM_CH-1:0]   dout;
  logic                dout_valid;
  logic [SLOT_W-1:0]   ch_sel;
  logic                locked;
  logic                sync_err;

  modport master (
    output en, din, sync,
    input  dout, dout_valid, ch_sel, locked, sync_err
  );

  modport slave (
    input  en, din, sync,
    output dout, dout_valid, ch_sel, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux_4ch_demux.sv
// Slot decoder: one-hot write enable per channel for the current strobe.
module demux_1to4
  import tdm_pkg::*;
(
  input  logic [SLOT_W-1:0] slot_i,
  input  logic              strobe_i,
  output logic [NUM_CH-1:0] we_o
);

  always_comb begin
    we_o         = '0;
    we_o[slot_i] = strobe_i;
  end

endmodule

// File: rtl/tdm_demux_4ch.sv
// 4-channel serial TDM demultiplexer with sync hunting, flywheel and loss-of-lock.
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int unsigned SYNC_LOSS_MAX = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  tdm_demux_4ch_if.slave   bus
);

  localparam int unsigned MW = (SYNC_LOSS_MAX < 2) ? 1 : $clog2(SYNC_LOSS_MAX + 1);
  localparam logic [MW-1:0] MISS_LIMIT = MW'(SYNC_LOSS_MAX);

  state_t              state_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [MW-1:0]       miss_q;
  logic [NUM_CH-2:0]   shadow_q;
  logic [NUM_CH-1:0]   dout_q;
  logic                dout_valid_q;
  logic                sync_err_q;

  logic                misplaced;
  logic                wr_strobe;
  logic [MW-1:0]       miss_inc;
  logic [NUM_CH-1:0]   we;

  // A sync away from slot 0 overrides the normal slot write path.
  assign misplaced = bus.sync && (slot_q != '0);
  assign wr_strobe = bus.en && (state_q == LOCKED) && !misplaced;
  assign miss_inc  = (miss_q == '1) ? miss_q : miss_q + 1'b1;

  demux_1to4 u_demux (
    .slot_i   (slot_q),
    .strobe_i (wr_strobe),
    .we_o     (we)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= '0;
      miss_q       <= '0;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (bus.en) begin
        case (state_q)
          HUNT: begin
            if (bus.sync) begin
              shadow_q[0] <= bus.din;
              slot_q      <= SLOT_W'(1);
              miss_q      <= '0;
              state_q     <= LOCKED;
            end
          end
          LOCKED: begin
            if (misplaced) begin
              sync_err_q <= 1'b1;
              if (miss_inc >= MISS_LIMIT) begin
                slot_q  <= '0;
                miss_q  <= '0;
                state_q <= HUNT;
              end else begin
                miss_q      <= miss_inc;
                shadow_q[0] <= bus.din;
                slot_q      <= SLOT_W'(1);
              end
            end else begin
              if (bus.sync) miss_q <= '0;
              if (we[0]) shadow_q[0] <= bus.din;
              if (we[1]) shadow_q[1] <= bus.din;
              if (we[2]) shadow_q[2] <= bus.din;
              if (we[3]) begin
                dout_q       <= {bus.din, shadow_q};
                dout_valid_q <= 1'b1;
              end
              slot_q <= slot_q + 1'b1;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.ch_sel     = slot_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed bench for tdm_demux_4ch with hand-computed expected outputs.
module tb_tdm_demux_4ch;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   vcount;

  tdm_demux_4ch_if bus ();

  tdm_demux_4ch #(.SYNC_LOSS_MAX(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] d, input logic v,
                            input logic e, input logic l, input logic [1:0] c);
    check({tag, ".dout"},       bus.dout,              d);
    check({tag, ".dout_valid"}, {3'b0, bus.dout_valid}, {3'b0, v});
    check({tag, ".sync_err"},   {3'b0, bus.sync_err},   {3'b0, e});
    check({tag, ".locked"},     {3'b0, bus.locked},     {3'b0, l});
    check({tag, ".ch_sel"},     {2'b0, bus.ch_sel},     {2'b0, c});
  endtask

  // One strobed bit; outputs sampled 1 time unit after the capturing edge.
  task automatic strobe(input logic d, input logic s);
    @(negedge clk);
    bus.en   = 1'b1;
    bus.din  = d;
    bus.sync = s;
    @(posedge clk);
    #1;
    bus.en   = 1'b0;
    bus.din  = 1'b0;
    bus.sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] fr [3];
    fr[0] = 4'b0001; fr[1] = 4'b0010; fr[2] = 4'b0111;

    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.din  = 1'b1;
    bus.sync = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 4'b0000, 0, 0, 0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.en = 1'b0; bus.din = 1'b0; bus.sync = 1'b0;

    // First frame 1,0,1,1 acquired on sync
    strobe(1, 1); expect_out("acq0", 4'b0000, 0, 0, 1, 2'd1);
    strobe(0, 0); expect_out("acq1", 4'b0000, 0, 0, 1, 2'd2);
    strobe(1, 0); expect_out("acq2", 4'b0000, 0, 0, 1, 2'd3);
    strobe(1, 0); expect_out("acq3", 4'b1101, 1, 0, 1, 2'd0);
    idle(1);      expect_out("acq_hold", 4'b1101, 0, 0, 1, 2'd0);

    // Frame 0,1,1,0 with en gaps
    strobe(0, 1); idle(2); expect_out("gap1", 4'b1101, 0, 0, 1, 2'd1);
    strobe(1, 0); idle(3); expect_out("gap2", 4'b1101, 0, 0, 1, 2'd2);
    strobe(1, 0);          expect_out("gap3", 4'b1101, 0, 0, 1, 2'd3);
    strobe(0, 0);          expect_out("gap_done", 4'b0110, 1, 0, 1, 2'd0);
    idle(1);               expect_out("gap_hold", 4'b0110, 0, 0, 1, 2'd0);

    // Misplaced sync at slot 2 realigns; that bit becomes channel 0
    strobe(1, 1); expect_out("ra0", 4'b0110, 0, 0, 1, 2'd1);
    strobe(0, 0); expect_out("ra1", 4'b0110, 0, 0, 1, 2'd2);
    strobe(1, 1); expect_out("ra_err", 4'b0110, 0, 1, 1, 2'd1);
    strobe(1, 0); expect_out("ra2", 4'b0110, 0, 0, 1, 2'd2);
    strobe(1, 0); expect_out("ra3", 4'b0110, 0, 0, 1, 2'd3);
    strobe(1, 0); expect_out("ra_done", 4'b1111, 1, 0, 1, 2'd0);

    // Two misplaced syncs in consecutive frames drop lock
    strobe(0, 1); expect_out("loss_good", 4'b1111, 0, 0, 1, 2'd1);
    strobe(1, 1); expect_out("loss_err1", 4'b1111, 0, 1, 1, 2'd1);
    strobe(0, 0);
    strobe(0, 0);
    strobe(0, 0); expect_out("loss_frame", 4'b0001, 1, 0, 1, 2'd0);
    strobe(0, 0); expect_out("loss_fly", 4'b0001, 0, 0, 1, 2'd1);
    strobe(1, 1); expect_out("loss_err2", 4'b0001, 0, 1, 0, 2'd0);
    strobe(1, 0); expect_out("hunt_discard", 4'b0001, 0, 0, 0, 2'd0);

    // Reset mid-frame with en=1 and sync=1
    strobe(1, 1); strobe(1, 0); expect_out("pre_rst", 4'b0001, 0, 0, 1, 2'd2);
    @(negedge clk);
    rst_n = 1'b0; bus.en = 1'b1; bus.din = 1'b1; bus.sync = 1'b1;
    @(posedge clk); #1;
    expect_out("mid_rst", 4'b0000, 0, 0, 0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.en = 1'b0; bus.din = 1'b0; bus.sync = 1'b0;
    strobe(0, 1); expect_out("reacq0", 4'b0000, 0, 0, 1, 2'd1);
    strobe(1, 0);
    strobe(0, 0);
    strobe(1, 0); expect_out("reacq_done", 4'b1010, 1, 0, 1, 2'd0);

    // Flywheel: three frames with no sync at all
    vcount = 0;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 4; b++) begin
        logic [3:0] w;
        w = fr[f];
        strobe(w[b], 0);
        if (bus.dout_valid) vcount++;
        check("fly_sync_err", {3'b0, bus.sync_err}, 4'd0);
        check("fly_ch_sel", {2'b0, bus.ch_sel}, 4'((b + 1) % 4));
      end
      check("fly_dout", bus.dout, fr[f]);
    end
    check("fly_valid_count", 4'(vcount), 4'd3);
    check("fly_locked", {3'b0, bus.locked}, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
